// File: rtl/incr_arbiter_if.sv
// ----------------------------------------------------------------------------
// incr_arbiter_if
//   Bundles the requester-side signals of incr_arbiter.
//   req  : per-requester increment request, held until ack
//   clr  : per-requester synchronous clear of count and overflow flag
//   gnt  : one-hot grant of the shared incrementer
//   ack  : one-hot, single-cycle commit acknowledge
//   cnt  : packed counts, requester i at [i*WIDTH +: WIDTH]
//   ovf  : sticky per-requester overflow flags
//   busy : arbiter is not idle
//   master : requester side (drives req/clr)
//   slave  : arbiter side (drives gnt/ack/cnt/ovf/busy)
// ----------------------------------------------------------------------------
interface incr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       clr;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [NREQ*WIDTH-1:0] cnt;
    logic [NREQ-1:0]       ovf;
    logic                  busy;

    modport master (
        output req,
        output clr,
        input  gnt,
        input  ack,
        input  cnt,
        input  ovf,
        input  busy
    );

    modport slave (
        input  req,
        input  clr,
        output gnt,
        output ack,
        output cnt,
        output ovf,
        output busy
    );
endinterface

// File: rtl/incr_arbiter.sv
// ----------------------------------------------------------------------------
// incr_arbiter
//   Shares a single WIDTH-bit +1 incrementer between NREQ requesters. Each
//   requester owns a count register and a sticky overflow flag. A round-robin
//   FSM (IDLE -> GRANT -> ACK) grants the incrementer, performs the
//   read-modify-write on the winner's count, and pulses the winner's ack.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous, active-high reset
//     bus   : incr_arbiter_if.slave (req/clr in; gnt/ack/cnt/ovf/busy out)
// ----------------------------------------------------------------------------
module incr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    incr_arbiter_if.slave  bus
);

    localparam int          PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR   = NREQ;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [PTRW-1:0]   sel_q, sel_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   ovf_q, ovf_d;
    logic [WIDTH-1:0]  cnt_q [NREQ];
    logic [WIDTH-1:0]  cnt_d [NREQ];

    // Round-robin search result
    logic              pick_found;
    logic [PTRW-1:0]   pick_idx;

    // The one shared incrementer
    logic [WIDTH-1:0]  inc_a;
    logic [WIDTH-1:0]  inc_sum;
    logic              inc_co;

    function automatic logic [NREQ-1:0] onehot(input logic [PTRW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester at or after ptr, searching cyclically. Because ptr is
    // always one past the last winner, the last winner is checked last.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(ptr_q) + k) % NR;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTRW'(idx);
            end
        end
    end

    always_comb begin
        inc_a             = cnt_q[sel_q];
        {inc_co, inc_sum} = {1'b0, inc_a} + (WIDTH+1)'(1);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        ack_d   = '0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Commits regardless of whether req is still held.
                cnt_d[sel_q] = inc_sum;
                if (inc_co) begin
                    ovf_d[sel_q] = 1'b1;
                end
                ack_d   = onehot(sel_q);
                ptr_d   = (sel_q == PTRW'(NR - 1)) ? '0 : sel_q + PTRW'(1);
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear is applied after the increment so it wins on the same edge;
        // the ack for that requester still pulses.
        for (int unsigned i = 0; i < NR; i++) begin
            if (bus.clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            ovf_q   <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.cnt = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            bus.cnt[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != IDLE);

endmodule
